step_pulse_gen: RTL and testbench

Transmit side of the step/dir interface. Turns a queued motion command (direction, step count, step period) into a clean STEP pulse train plus a DIR level, with guaranteed pulse width and DIR setup time. Sits between the command/host logic and the driver pins. Its output is the signal that edge_detector_debounced consumes on the receive side.

---
 rtl/step_gen_pkg.sv | 21 ++
 rtl/step_phase_timer.sv | 37 +++
 rtl/step_pulse_gen.sv | 199 +++++++++++++++++++
 tb/tb_step_pulse_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_gen_pkg.sv
// Shared definitions for the step/dir transmitter: state encoding, default
// pulse timing constants and clock-rate helpers.
package step_gen_pkg;

    // Default timing, in clk cycles at CLK_HZ
    localparam int PULSE_CYC     = 15;
    localparam int DIR_SETUP_CYC = 10;

    localparam int CLK_HZ      = 100_000_000;
    // Step period for a 250 kHz step rate (400 cycles at 100 MHz)
    localparam int PERIOD_250K = CLK_HZ / 250_000;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DIR_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH      = 3'd2;
    localparam logic [2:0] S_LOW       = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

endpackage

// File: rtl/step_phase_timer.sv
// Loadable down-counter timing the DIR setup, STEP high and STEP low phases.
// A load of N makes zero assert N cycles later; the count parks at zero.
module step_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; otherwise count down and hold at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Step/dir transmitter: converts one accepted motion command into a STEP
// pulse train with fixed high time and a DIR level with guaranteed setup.
// Optional abort support is compiled in with the STEP_ABORT_EN macro.
module step_pulse_gen #(
    parameter int PULSE_CYC     = step_gen_pkg::PULSE_CYC,
    parameter int DIR_SETUP_CYC = step_gen_pkg::DIR_SETUP_CYC,
    parameter int PERIOD_W      = 16,
    parameter int COUNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                step_out,
    output logic                dir_out,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  steps_left
);
    import step_gen_pkg::*;

    localparam logic [PERIOD_W-1:0] PULSE_LEN  = PERIOD_W'(PULSE_CYC);
    localparam logic [PERIOD_W-1:0] PULSE_LOAD = PERIOD_W'(PULSE_CYC - 1);
    localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP_CYC - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CYC);
    localparam logic [COUNT_W-1:0]  ONE_STEP   = COUNT_W'(1);

    state_t               state_q, state_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [COUNT_W-1:0]   left_q, left_d;
    logic [PERIOD_W-1:0]  period_q, period_d;

    logic                 tmr_load;
    logic [PERIOD_W-1:0]  tmr_val;
    logic                 tmr_zero;
    logic [PERIOD_W-1:0]  low_load;

    logic                 abort_now;   // abort request this cycle
    logic                 abort_hold;  // abort seen earlier in the current HIGH

    step_phase_timer #(
        .W (PERIOD_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    // Effective period is already clamped, so the low time never underflows
    assign low_load = period_q - PULSE_LEN - PERIOD_W'(1);

`ifdef STEP_ABORT_EN
    logic abort_pend_q, abort_pend_d;

    assign abort_now  = abort;
    assign abort_hold = abort_pend_q;

    // Remember an abort raised during HIGH until the pulse has finished
    always_comb begin
        abort_pend_d = (state_q == S_HIGH) && !tmr_zero && (abort_pend_q || abort);
    end

    // Pending-abort register
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_pend_q <= 1'b0;
        end else begin
            abort_pend_q <= abort_pend_d;
        end
    end
`else
    logic abort_unused;

    assign abort_unused = abort;
    assign abort_now    = 1'b0;
    assign abort_hold   = 1'b0;
`endif

    // Command sequencer: next state, pin levels, step count and timer loads
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        dir_d    = dir_q;
        left_d   = left_q;
        period_d = period_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    period_d = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
                    left_d   = cmd_steps;
                    if (cmd_steps == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_dir != dir_q) begin
                        dir_d    = cmd_dir;
                        state_d  = S_DIR_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LOAD;
                    end else begin
                        state_d  = S_HIGH;
                        step_d   = 1'b1;
                        left_d   = cmd_steps - ONE_STEP;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LOAD;
                    end
                end
            end
            S_DIR_SETUP: begin
                if (abort_now) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    state_d  = S_HIGH;
                    step_d   = 1'b1;
                    left_d   = left_q - ONE_STEP;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                end
            end
            S_HIGH: begin
                // The full high time always completes, even when aborting
                if (tmr_zero) begin
                    step_d = 1'b0;
                    if (abort_hold || abort_now) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_LOW;
                        tmr_load = 1'b1;
                        tmr_val  = low_load;
                    end
                end
            end
            S_LOW: begin
                if (abort_now) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    if (left_q != '0) begin
                        state_d  = S_HIGH;
                        step_d   = 1'b1;
                        left_d   = left_q - ONE_STEP;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // Sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            left_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            left_q   <= left_d;
            period_q <= period_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !rst;
    assign step_out   = step_q;
    assign dir_out    = dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign steps_left = left_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: table of commands with hand-computed timing
// expectations, scoreboard queue popped on done, plus hand-written sequences
// for back-to-back handshake, abort in IDLE and reset mid-command.
// Abort expectations follow the STEP_ABORT_EN macro.
module tb_step_pulse_gen;

    localparam int PULSE = 15;

    typedef struct {
        logic dir;
        int   steps;
        int   period;
        int   abort_at;   // cycle after accept to pulse abort, 0 = none
        int   pulses;
        int   first;      // cycle of first STEP rise after accept, -1 = none
        int   spacing;
        int   done_t;     // cycle after accept where done is high
        logic exp_dir;
        int   left;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic [15:0] steps_left;

    int checks   = 0;
    int failures = 0;
    vec_t sb_q[$];
    vec_t tbl[9];

    step_pulse_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic d, input int s, input int p, input int ab,
                                input int np, input int f, input int sp, input int dt,
                                input logic ed, input int l);
        vec_t v;
        v.dir = d; v.steps = s; v.period = p; v.abort_at = ab;
        v.pulses = np; v.first = f; v.spacing = sp; v.done_t = dt;
        v.exp_dir = ed; v.left = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Follows one command from its accept edge until done, then scores it
    task automatic measure(input string name, input bit hold_alt, input logic adir,
                           input logic [15:0] asteps, input logic [15:0] aper,
                           input int abort_at);
        int   t = 0;
        int   pulses = 0;
        int   first = -1;
        int   last_rise = 0;
        int   sp_min = 1 << 30;
        int   sp_max = 0;
        int   hi_min = 1 << 30;
        int   hi_max = 0;
        int   hi_run = 0;
        logic prev_step = 1'b0;
        logic prev_dir = dir_out;
        bit   dir_bad = 1'b0;
        bit   got_done = 1'b0;
        logic busy_t1 = 1'b0;
        logic ready_t1 = 1'b1;
        logic busy_at_done = 1'b1;
        vec_t e;
        while (!got_done && t < 4000) begin
            @(posedge clk);
            @(negedge clk);
            t++;
            if (t == 1) begin
                if (hold_alt) begin
                    cmd_dir = adir; cmd_steps = asteps; cmd_period = aper;
                end else begin
                    cmd_valid = 1'b0;
                end
                busy_t1  = busy;
                ready_t1 = cmd_ready;
            end
            abort = (t == abort_at);
            if (step_out && !prev_step) begin
                pulses++;
                if (first < 0) begin
                    first = t;
                end else begin
                    if (t - last_rise < sp_min) sp_min = t - last_rise;
                    if (t - last_rise > sp_max) sp_max = t - last_rise;
                end
                last_rise = t;
                hi_run = 0;
            end
            if (step_out) begin
                hi_run++;
            end else if (prev_step) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
            end
            if (dir_out !== prev_dir && (t >= 2 || step_out || prev_step)) dir_bad = 1'b1;
            prev_step = step_out;
            prev_dir  = dir_out;
            if (done) begin
                got_done = 1'b1;
                busy_at_done = busy;
            end
        end
        abort = 1'b0;
        check({name, "_done_seen"}, 32'(got_done), 32'd1);
        if (sb_q.size() == 0) begin
            check({name, "_scoreboard"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_pulses"}, 32'(pulses), 32'(e.pulses));
            check({name, "_first_rise"}, 32'(first), 32'(e.first));
            check({name, "_done_time"}, 32'(t), 32'(e.done_t));
            check({name, "_dir"}, 32'(dir_out), 32'(e.exp_dir));
            check({name, "_steps_left"}, 32'(steps_left), 32'(e.left));
            check({name, "_busy_t1"}, 32'(busy_t1), 32'd1);
            check({name, "_ready_t1"}, 32'(ready_t1), 32'd0);
            check({name, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
            check({name, "_dir_stable"}, 32'(dir_bad), 32'd0);
            if (e.pulses > 0) begin
                check({name, "_high_min"}, 32'(hi_min), 32'(PULSE));
                check({name, "_high_max"}, 32'(hi_max), 32'(PULSE));
            end
            if (e.pulses > 1) begin
                check({name, "_spacing_min"}, 32'(sp_min), 32'(e.spacing));
                check({name, "_spacing_max"}, 32'(sp_max), 32'(e.spacing));
            end
        end
        $display("txn %s pulses=%0d first=%0d spacing=%0d..%0d high=%0d..%0d done_t=%0d dir=%0d left=%0d",
                 name, pulses, first, sp_min, sp_max, hi_min, hi_max, t, dir_out, steps_left);
    endtask

    initial begin
        bit saw_done;

        // dir, steps, period, abort_at | pulses, first, spacing, done_t, dir, left
        tbl[0] = mk(1'b0, 4, 400, 0,   4, 1,  400, 1602, 1'b0, 0);
        tbl[1] = mk(1'b1, 2, 400, 0,   2, 11, 400, 812,  1'b1, 0);
        tbl[2] = mk(1'b0, 0, 400, 0,   0, -1, 0,   2,    1'b1, 0);
        tbl[3] = mk(1'b1, 3, 5,   0,   3, 1,  30,  92,   1'b1, 0);
        tbl[4] = mk(1'b0, 2, 31,  0,   2, 11, 31,  74,   1'b0, 0);
        tbl[5] = mk(1'b0, 10, 30, 0,   10, 1, 30,  302,  1'b0, 0);
        tbl[6] = mk(1'b1, 2, 29,  0,   2, 11, 30,  72,   1'b1, 0);
        tbl[7] = mk(1'b1, 1, 400, 0,   1, 1,  0,   402,  1'b1, 0);
`ifdef STEP_ABORT_EN
        tbl[8] = mk(1'b1, 8, 40,  85,  3, 1,  40,  97,   1'b1, 5);
`else
        tbl[8] = mk(1'b1, 8, 40,  85,  8, 1,  40,  322,  1'b1, 0);
`endif

        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
        cmd_steps = '0; cmd_period = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_step", 32'(step_out), 32'd0);
        check("reset_dir", 32'(dir_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_left", 32'(steps_left), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(cmd_ready), 32'd1);

        // Table of commands
        for (int i = 0; i < 9; i++) begin
            wait_ready($sformatf("vec%0d", i));
            cmd_dir = tbl[i].dir;
            cmd_steps = 16'(tbl[i].steps);
            cmd_period = 16'(tbl[i].period);
            cmd_valid = 1'b1;
            sb_q.push_back(tbl[i]);
            measure($sformatf("vec%0d", i), 1'b0, 1'b0, 16'd0, 16'd0, tbl[i].abort_at);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
        end

        // cmd_valid held with other fields during a command: ignored until
        // the done cycle, then accepted back-to-back
        wait_ready("hold");
        cmd_dir = 1'b0; cmd_steps = 16'd2; cmd_period = 16'd5; cmd_valid = 1'b1;
        sb_q.push_back(mk(1'b0, 2, 5, 0, 2, 11, 30, 72, 1'b0, 0));
        measure("hold_main", 1'b1, 1'b1, 16'd1, 16'd60, 0);
        check("hold_ready_at_done", 32'(cmd_ready), 32'd1);
        sb_q.push_back(mk(1'b1, 1, 60, 0, 1, 11, 0, 72, 1'b1, 0));
        measure("hold_alt", 1'b0, 1'b0, 16'd0, 16'd0, 0);
        @(negedge clk);

        // abort while idle has no effect
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_done", 32'(done), 32'd0);
        check("idle_abort_ready", 32'(cmd_ready), 32'd1);

        // reset in the middle of a STEP high phase
        cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd40; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_step_before", 32'(step_out), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_step", 32'(step_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_left", 32'(steps_left), 32'd0);
        check("midrst_dir", 32'(dir_out), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || step_out) saw_done = 1'b1;
        end
        check("midrst_quiet", 32'(saw_done), 32'd0);
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);
        $display("txn reset_mid_command step=%0d busy=%0d ready=%0d", step_out, busy, cmd_ready);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
